// File: rtl/axil_mem_ctrl_if.sv
// AXI-Lite request/response struct types (default 16-bit address, 64-bit data)
// and the bus interface that bundles them for the axil_mem_ctrl bridge.
package axil_mem_ctrl_pkg;
    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 64;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
    } aw_chan_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
    } ar_chan_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } resp_t;
endpackage

interface axil_mem_ctrl_if #(
    parameter type req_t  = axil_mem_ctrl_pkg::req_t,
    parameter type resp_t = axil_mem_ctrl_pkg::resp_t
);
    req_t  req;
    resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/axil_mem_ctrl.sv
// AXI-Lite slave to single-port synchronous memory bridge, one transaction in flight.
// Optional AXIL_MEM_CTRL_ZERO_STRB_ERR_EN: all-zero-strobe writes skip memory and answer SLVERR.
module axil_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter type req_t  = axil_mem_ctrl_pkg::req_t,
    parameter type resp_t = axil_mem_ctrl_pkg::resp_t,
    localparam int unsigned OFS = $clog2(DATA_WIDTH / 8)
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  req_t                      req_i,
    output resp_t                     resp_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-OFS-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_RESP = 2'd2;
    localparam logic [1:0] WR_RESP = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]            state;
    logic                  last_wr;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  b_err_q;

    logic idle;
    logic rd_req;
    logic wr_req;
    logic grant_rd;
    logic grant_wr;
    logic strb_err;

    // Grants are combinational; gating with arst_ni keeps every ready low while reset is held.
    assign idle   = (state == IDLE) && arst_ni;
    assign rd_req = req_i.ar_valid;
    assign wr_req = req_i.aw_valid && req_i.w_valid;

    assign grant_rd = idle && rd_req && (!wr_req || last_wr);
    assign grant_wr = idle && wr_req && (!rd_req || !last_wr);

`ifdef AXIL_MEM_CTRL_ZERO_STRB_ERR_EN
    assign strb_err = grant_wr && (req_i.w.strb == '0);
`else
    assign strb_err = 1'b0;
`endif

    assign mem_req_o   = grant_rd || (grant_wr && !strb_err);
    assign mem_we_o    = grant_wr && !strb_err;
    assign mem_addr_o  = grant_rd ? req_i.ar.addr[ADDR_WIDTH-1:OFS]
                                  : req_i.aw.addr[ADDR_WIDTH-1:OFS];
    assign mem_wdata_o = req_i.w.data;
    assign mem_be_o    = req_i.w.strb;

    // Sub-word address bits carry no meaning for a word-wide memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{req_i.ar.addr[OFS-1:0], req_i.aw.addr[OFS-1:0]};

    always_comb begin
        // NOTE: the whole struct gets a default first, so no field can infer a latch.
        resp_o          = '0;
        resp_o.ar_ready = grant_rd;
        resp_o.aw_ready = grant_wr;
        resp_o.w_ready  = grant_wr;
        resp_o.r_valid  = (state == RD_RESP);
        resp_o.r.data   = rdata_q;
        resp_o.r.resp   = RESP_OKAY;
        resp_o.b_valid  = (state == WR_RESP);
        resp_o.b.resp   = b_err_q ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state   <= IDLE;
            last_wr <= 1'b1;
            rdata_q <= '0;
            b_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        state   <= RD_WAIT;
                        last_wr <= 1'b0;
                    end else if (grant_wr) begin
                        state   <= WR_RESP;
                        last_wr <= 1'b1;
                        b_err_q <= strb_err;
                    end
                end
                RD_WAIT: begin
                    rdata_q <= mem_rdata_i;
                    state   <= RD_RESP;
                end
                RD_RESP: if (req_i.r_ready) state <= IDLE;
                WR_RESP: if (req_i.b_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_mem_ctrl.sv
// Directed bench for axil_mem_ctrl: a behavioural word memory with one-cycle read latency,
// hand-computed expectations checked with immediate assertions.
module tb_axil_mem_ctrl;

    logic        clk;
    logic        arst_ni;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    axil_mem_ctrl_if bus ();

    axil_mem_ctrl dut (
        .clk_i       (clk),
        .arst_ni     (arst_ni),
        .req_i       (bus.req),
        .resp_o      (bus.resp),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten words read back as C0DE_0000_0000_<word index>.
    logic [63:0] mem [int];
    logic [63:0] wword;
    always @(posedge clk) begin
        mem_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
        if (mem_req && !mem_we)
            mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)]
                                                    : {16'hC0DE, 35'd0, mem_addr};
        if (mem_req && mem_we) begin
            wword = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : {16'hC0DE, 35'd0, mem_addr};
            for (int b = 0; b < 8; b++)
                if (mem_be[b]) wword[b*8 +: 8] = mem_wdata[b*8 +: 8];
            mem[int'(mem_addr)] = wword;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.req = '0;
    endtask

    logic [1:0] exp_zresp;

    initial begin
        // Reset holds every ready/valid low even with requests pending.
        arst_ni = 1'b0;
        clear();
        bus.req.ar_valid = 1'b1;
        bus.req.aw_valid = 1'b1;
        bus.req.w_valid  = 1'b1;
        #2;
        check("rst_ar_ready", bus.resp.ar_ready, 0);
        check("rst_aw_ready", bus.resp.aw_ready, 0);
        check("rst_mem_req",  mem_req, 0);
        check("rst_mem_we",   mem_we, 0);
        check("rst_r_valid",  bus.resp.r_valid, 0);
        check("rst_b_valid",  bus.resp.b_valid, 0);
        check("rst_r_data",   bus.resp.r.data, 0);
        clear();
        tick();
        tick();
        arst_ni = 1'b1;

        // Write 0x0010 then read it back.
        bus.req.aw.addr  = 16'h0010;
        bus.req.aw_valid = 1'b1;
        bus.req.w.data   = 64'h1122_3344_5566_7788;
        bus.req.w.strb   = 8'hFF;
        bus.req.w_valid  = 1'b1;
        #1;
        check("wr_aw_ready", bus.resp.aw_ready, 1);
        check("wr_w_ready",  bus.resp.w_ready, 1);
        check("wr_mem_req",  mem_req, 1);
        check("wr_mem_we",   mem_we, 1);
        check("wr_mem_addr", mem_addr, 2);
        check("wr_mem_be",   mem_be, 8'hFF);
        check("wr_wdata",    mem_wdata, 64'h1122_3344_5566_7788);
        tick();
        bus.req.aw_valid = 1'b0;
        bus.req.w_valid  = 1'b0;
        #1;
        check("wr_b_valid", bus.resp.b_valid, 1);
        check("wr_b_resp",  bus.resp.b.resp, 0);
        check("wr_resp_mem_req", mem_req, 0);
        check("wr_resp_r_valid", bus.resp.r_valid, 0);
        bus.req.b_ready = 1'b1;
        tick();
        bus.req.b_ready = 1'b0;
        #1;
        check("wr_b_done", bus.resp.b_valid, 0);

        bus.req.ar.addr  = 16'h0010;
        bus.req.ar_valid = 1'b1;
        #1;
        check("rd_ar_ready", bus.resp.ar_ready, 1);
        check("rd_mem_req",  mem_req, 1);
        check("rd_mem_we",   mem_we, 0);
        check("rd_mem_addr", mem_addr, 2);
        tick();
        bus.req.ar_valid = 1'b0;
        #1;
        check("rd_wait_r_valid", bus.resp.r_valid, 0);
        tick();
        #1;
        check("rd_r_valid", bus.resp.r_valid, 1);
        check("rd_r_data",  bus.resp.r.data, 64'h1122_3344_5566_7788);
        check("rd_r_resp",  bus.resp.r.resp, 0);
        check("rd_b_valid", bus.resp.b_valid, 0);
        bus.req.r_ready = 1'b1;
        tick();
        bus.req.r_ready = 1'b0;
        #1;
        check("rd_r_done", bus.resp.r_valid, 0);

        // Read/write conflict from reset: read first, then alternation.
        arst_ni = 1'b0;
        tick();
        arst_ni = 1'b1;
        bus.req.ar.addr  = 16'h0008;
        bus.req.ar_valid = 1'b1;
        bus.req.aw.addr  = 16'h0020;
        bus.req.aw_valid = 1'b1;
        bus.req.w.data   = 64'hAAAA_BBBB_CCCC_DDDD;
        bus.req.w.strb   = 8'hFF;
        bus.req.w_valid  = 1'b1;
        #1;
        check("cf1_ar_ready", bus.resp.ar_ready, 1);
        check("cf1_aw_ready", bus.resp.aw_ready, 0);
        check("cf1_mem_addr", mem_addr, 1);
        check("cf1_mem_we",   mem_we, 0);
        tick();
        bus.req.ar_valid = 1'b0;
        #1;
        check("cf1_wait_aw_ready", bus.resp.aw_ready, 0);
        tick();
        #1;
        check("cf1_r_data",   bus.resp.r.data, 64'hC0DE_0000_0000_0001);
        check("cf1_resp_aw_ready", bus.resp.aw_ready, 0);
        bus.req.r_ready = 1'b1;
        #1;
        check("cf1_hs_aw_ready", bus.resp.aw_ready, 0);
        tick();
        bus.req.r_ready  = 1'b0;
        bus.req.ar_valid = 1'b1;
        #1;
        check("cf2_aw_ready", bus.resp.aw_ready, 1);
        check("cf2_w_ready",  bus.resp.w_ready, 1);
        check("cf2_ar_ready", bus.resp.ar_ready, 0);
        check("cf2_mem_addr", mem_addr, 4);
        check("cf2_mem_we",   mem_we, 1);
        tick();
        bus.req.aw_valid = 1'b0;
        bus.req.w_valid  = 1'b0;
        #1;
        check("cf2_b_valid",  bus.resp.b_valid, 1);
        check("cf2_resp_ar_ready", bus.resp.ar_ready, 0);
        bus.req.b_ready = 1'b1;
        tick();
        bus.req.b_ready  = 1'b0;
        bus.req.aw_valid = 1'b1;
        bus.req.w_valid  = 1'b1;
        #1;
        check("cf3_ar_ready", bus.resp.ar_ready, 1);
        check("cf3_aw_ready", bus.resp.aw_ready, 0);
        tick();
        bus.req.ar_valid = 1'b0;
        tick();
        #1;
        check("cf3_r_data", bus.resp.r.data, 64'hC0DE_0000_0000_0001);
        bus.req.r_ready = 1'b1;
        tick();
        bus.req.r_ready = 1'b0;
        #1;
        check("cf3_aw_ready", bus.resp.aw_ready, 1);
        tick();
        bus.req.aw_valid = 1'b0;
        bus.req.w_valid  = 1'b0;
        bus.req.b_ready  = 1'b1;
        tick();
        bus.req.b_ready = 1'b0;

        // A lone channel never gets a grant.
        bus.req.w.data  = 64'h0000_0000_CAFE_F00D;
        bus.req.w.strb  = 8'h0F;
        bus.req.w_valid = 1'b1;
        #1;
        check("wonly_w_ready", bus.resp.w_ready, 0);
        tick();
        bus.req.w_valid  = 1'b0;
        bus.req.aw.addr  = 16'h0040;
        bus.req.aw_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("awonly_aw_ready", bus.resp.aw_ready, 0);
            check("awonly_mem_req",  mem_req, 0);
            tick();
        end
        bus.req.w_valid = 1'b1;
        #1;
        check("aw_w_aw_ready", bus.resp.aw_ready, 1);
        check("aw_w_w_ready",  bus.resp.w_ready, 1);
        check("aw_w_mem_be",   mem_be, 8'h0F);
        check("aw_w_mem_addr", mem_addr, 8);
        tick();
        bus.req.aw_valid = 1'b0;
        bus.req.w_valid  = 1'b0;
        bus.req.b_ready  = 1'b1;
        tick();
        bus.req.b_ready = 1'b0;

        // Response held under r_ready backpressure; pending write must wait.
        bus.req.ar.addr  = 16'h0018;
        bus.req.ar_valid = 1'b1;
        #1;
        check("bp_ar_ready", bus.resp.ar_ready, 1);
        check("bp_mem_addr", mem_addr, 3);
        tick();
        bus.req.ar_valid = 1'b0;
        tick();
        bus.req.aw.addr  = 16'h0050;
        bus.req.w.strb   = 8'hFF;
        bus.req.aw_valid = 1'b1;
        bus.req.w_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_r_valid",  bus.resp.r_valid, 1);
            check("bp_r_data",   bus.resp.r.data, 64'hC0DE_0000_0000_0003);
            check("bp_aw_ready", bus.resp.aw_ready, 0);
            tick();
        end
        bus.req.r_ready = 1'b1;
        #1;
        check("bp_hs_aw_ready", bus.resp.aw_ready, 0);
        tick();
        bus.req.r_ready = 1'b0;
        #1;
        check("bp_idle_r_valid",  bus.resp.r_valid, 0);
        check("bp_idle_aw_ready", bus.resp.aw_ready, 1);
        tick();
        bus.req.aw_valid = 1'b0;
        bus.req.w_valid  = 1'b0;
        bus.req.b_ready  = 1'b1;
        tick();
        bus.req.b_ready = 1'b0;

        // Reset in RD_WAIT drops the read.
        bus.req.ar.addr  = 16'h0010;
        bus.req.ar_valid = 1'b1;
        #1;
        check("ri_ar_ready", bus.resp.ar_ready, 1);
        tick();
        bus.req.ar_valid = 1'b0;
        arst_ni = 1'b0;
        #1;
        check("ri_r_valid", bus.resp.r_valid, 0);
        check("ri_mem_req", mem_req, 0);
        check("ri_r_data",  bus.resp.r.data, 0);
        tick();
        tick();
        arst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ri_after_r_valid", bus.resp.r_valid, 0);
            tick();
        end
        bus.req.ar_valid = 1'b1;
        #1;
        check("ri_next_ar_ready", bus.resp.ar_ready, 1);
        tick();
        bus.req.ar_valid = 1'b0;
        tick();
        #1;
        check("ri_next_r_valid", bus.resp.r_valid, 1);
        check("ri_next_r_data",  bus.resp.r.data, 64'h1122_3344_5566_7788);
        bus.req.r_ready = 1'b1;
        tick();
        bus.req.r_ready = 1'b0;

        // All-zero strobe write.
        bus.req.aw.addr  = 16'h0028;
        bus.req.w.data   = 64'h0000_0000_0000_5555;
        bus.req.w.strb   = 8'h00;
        bus.req.aw_valid = 1'b1;
        bus.req.w_valid  = 1'b1;
        #1;
        check("z_aw_ready", bus.resp.aw_ready, 1);
`ifdef AXIL_MEM_CTRL_ZERO_STRB_ERR_EN
        exp_zresp = 2'b10;
        check("z_mem_req", mem_req, 0);
`else
        exp_zresp = 2'b00;
        check("z_mem_req", mem_req, 1);
        check("z_mem_we",  mem_we, 1);
        check("z_mem_be",  mem_be, 8'h00);
`endif
        tick();
        bus.req.aw_valid = 1'b0;
        bus.req.w_valid  = 1'b0;
        #1;
        check("z_b_valid", bus.resp.b_valid, 1);
        check("z_b_resp",  bus.resp.b.resp, exp_zresp);
        bus.req.b_ready = 1'b1;
        tick();
        bus.req.b_ready  = 1'b0;
        bus.req.w.strb   = 8'h01;
        bus.req.aw_valid = 1'b1;
        bus.req.w_valid  = 1'b1;
        #1;
        check("nz_mem_req", mem_req, 1);
        tick();
        bus.req.aw_valid = 1'b0;
        bus.req.w_valid  = 1'b0;
        #1;
        check("nz_b_resp", bus.resp.b.resp, 0);
        bus.req.b_ready = 1'b1;
        tick();
        bus.req.b_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_mem_ctrl.md
AXIL_MEM_CTRL -- requirements
Module: axil_mem_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 16: byte-address width of the AXI-Lite port.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 64: data width, a power of two, 32 or more.
REQ-003 The module SHALL have parameters req_t and resp_t, each an AXI-Lite request/response struct type with addr[ADDR_WIDTH], data[DATA_WIDTH] and strb[DATA_WIDTH/8].
REQ-004 Derived constant: OFS = log2(DATA_WIDTH/8).
REQ-005 The module SHALL have the following ports:
  - clk_i, in, 1: single clock; all logic rising-edge.
  - arst_ni, in, 1: asynchronous, active-low reset.
  - req_i, in, req_t: AXI-Lite request channels.
  - resp_o, out, resp_t: AXI-Lite response channels.
  - mem_req_o, out, 1: memory access strobe.
  - mem_we_o, out, 1: write enable, qualified by mem_req_o.
  - mem_addr_o, out, ADDR_WIDTH-OFS: word address = addr[ADDR_WIDTH-1:OFS].
  - mem_wdata_o, out, DATA_WIDTH: write data.
  - mem_be_o, out, DATA_WIDTH/8: byte enables.
  - mem_rdata_i, in, DATA_WIDTH: read data, valid exactly one cycle after a read strobe.

Function
REQ-006 FSM states SHALL be IDLE, RD_WAIT, RD_RESP and WR_RESP; one transaction SHALL be in flight at a time.
REQ-007 In IDLE, ar_ready SHALL be 1 only when a read is granted that cycle; aw_ready and w_ready SHALL be 1 together only when a write is granted with aw_valid and w_valid both high.
REQ-008 A write SHALL NOT be granted on aw_valid alone or on w_valid alone; the valid channel waits.
REQ-009 When a read and a complete write request together in IDLE, the grant SHALL go to the type not granted last; the last-grant flag resets to "write", so the first conflict grants the read.
REQ-010 On a read grant at cycle T: mem_req_o=1, mem_we_o=0, mem_addr_o=ar.addr word, and the FSM SHALL move to RD_WAIT.
REQ-011 At T+1 the block SHALL capture mem_rdata_i into the rdata register and move to RD_RESP.
REQ-012 From T+2, r_valid SHALL be 1 with r.data = the rdata register and r.resp = OKAY, held stable until r_ready; on the handshake the FSM SHALL return to IDLE.
REQ-013 On a write grant at cycle T: mem_req_o=1, mem_we_o=1, address/wdata/be from aw/w, and the FSM SHALL move to WR_RESP.
REQ-014 From T+1, b_valid SHALL be 1, held until b_ready; on the handshake the FSM SHALL return to IDLE.
REQ-015 No new grant SHALL occur in the cycle an r or b handshake completes; minimum spacing is 3 cycles per read and 2 per write.
REQ-016 mem_req_o SHALL be 1 only in grant cycles; at all other times mem_addr_o, mem_wdata_o and mem_be_o are don't-care.
REQ-017 The low OFS address bits SHALL be ignored, with no alignment error.
REQ-018 r_valid and b_valid SHALL never be 1 simultaneously.

Reset
REQ-019 Asserting arst_ni low SHALL immediately force state IDLE, last-grant flag "write", rdata register 0, and all ready/valid outputs and mem_req_o/mem_we_o to 0.
REQ-020 A transaction in flight when reset asserts SHALL be dropped, with no response after reset release.
REQ-021 The first grant SHALL be possible in the first clock edge after deassertion.

Configuration
REQ-022 Macro AXIL_MEM_CTRL_ZERO_STRB_ERR_EN, defined: a granted write with strb all-zero SHALL drive mem_req_o=0 and return b.resp=SLVERR (2'b10), timing otherwise unchanged.
REQ-023 Macro AXIL_MEM_CTRL_ZERO_STRB_ERR_EN, undefined: such a write SHALL issue mem_req_o=1, mem_we_o=1, mem_be_o=0 and return b.resp=OKAY.
REQ-024 All other responses SHALL be OKAY in both builds.

Verification
REQ-025 Write addr 0x0010, data 0x1122334455667788, strb 0xFF, then read addr 0x0010 -> mem_addr_o=2 on both accesses, b_valid at T+1, r.data=0x1122334455667788 at T+2, resp OKAY.
REQ-026 Same-cycle ar (0x0008) and aw+w (0x0020) from reset -> read granted first, write granted in the IDLE cycle after the r handshake; repeat the conflict -> the grant alternates.
REQ-027 aw_valid held 5 cycles with w_valid low -> no aw_ready, no mem_req_o; w_valid rises -> aw_ready=w_ready=1 in the same cycle.
REQ-028 r_ready low 4 cycles after a read of 0x0018 -> r_valid and r.data stable all 4 cycles, no other grant; r_ready high -> IDLE next cycle.
REQ-029 arst_ni pulsed low while in RD_WAIT -> outputs 0 immediately, no r_valid after release, next read completes normally.
REQ-030 Write with strb 0x00 -> SLVERR and no mem_req_o with AXIL_MEM_CTRL_ZERO_STRB_ERR_EN defined; OKAY with mem_be_o=0 without it.
